// File: rtl/fir4_rr_sched_if.sv
// Producer/consumer bundle for the shared 4-tap moving-sum scheduler.
interface fir4_rr_sched_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
);
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W+1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;
    logic           busy;

    // Producers and consumer drive samples and out_ready; the block answers.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/fir4_rr_sched.sv
// Round-robin shared serial 4-tap moving-sum over N channel delay lines.
module fir4_rr_sched #(
    parameter int unsigned W  = 16,
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    fir4_rr_sched_if.slave     bus
);
    localparam int unsigned AW = W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_dl [N][4];
    logic [AW-1:0]  r_acc;
    logic [AW-1:0]  r_out_data;
    logic [CW-1:0]  r_out_ch;
    logic [CW-1:0]  r_ch;
    logic [CW-1:0]  r_rr_ptr;
    logic [1:0]     r_k;
    logic [CW-1:0]  w_grant;
    logic           w_gnt_vld;
    logic [W-1:0]   w_gdata;
    logic [W-1:0]   w_tap;
    logic           w_accept;
    logic           w_acc_step;
    logic           w_out_hs;
    logic [N-1:0]   w_in_ready_c;

    // Priority scan from rr_ptr upward; later hits are overwritten by nearer ones.
    always_comb begin
        logic [CW-1:0] v_idx;
        w_grant   = '0;
        w_gnt_vld = 1'b0;
        w_gdata   = '0;
        v_idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v_idx = CW'((32'(r_rr_ptr) + (N - 1 - i)) % N);
            if (bus.in_valid[v_idx]) begin
                w_grant   = v_idx;
                w_gnt_vld = 1'b1;
            end
        end
        for (int unsigned c = 0; c < N; c++) begin
            if (CW'(c) == w_grant) begin
                w_gdata = bus.in_data[c*W +: W];
            end
        end
    end

    assign w_tap = r_dl[r_ch][r_k];

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath enables.
    always_comb begin
        w_next       = r_state;
        w_in_ready_c = '0;
        w_accept     = 1'b0;
        w_acc_step   = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_in_ready_c[w_grant] = 1'b1;
                    w_accept              = 1'b1;
                    w_next                = S_ACC;
                end
            end
            S_ACC: begin
                w_acc_step = 1'b1;
                if (r_k == 2'd3) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_out_hs = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Delay lines, serial accumulator, result hold registers and rr pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dl       <= '{default: '0};
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_ch       <= '0;
            r_rr_ptr   <= '0;
            r_k        <= '0;
        end else begin
            if (w_accept) begin
                r_dl[w_grant][3] <= r_dl[w_grant][2];
                r_dl[w_grant][2] <= r_dl[w_grant][1];
                r_dl[w_grant][1] <= r_dl[w_grant][0];
                r_dl[w_grant][0] <= w_gdata;
                r_ch             <= w_grant;
                r_acc            <= '0;
                r_k              <= '0;
            end
            if (w_acc_step) begin
                r_acc <= r_acc + AW'(w_tap);
                r_k   <= r_k + 2'd1;
                if (r_k == 2'd3) begin
                    r_out_data <= r_acc + AW'(w_tap);
                    r_out_ch   <= r_ch;
                end
            end
            if (w_out_hs) begin
                r_rr_ptr <= (r_ch == CW'(N - 1)) ? '0 : r_ch + CW'(1);
            end
        end
    end

    // in_ready is held low while reset is asserted even if producers are valid.
    assign bus.in_ready  = reset ? '0 : w_in_ready_c;
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir4_rr_sched.sv
// Randomised and directed bench for fir4_rr_sched against a transaction-level model.
module tb_fir4_rr_sched;
    localparam int unsigned W  = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir4_rr_sched_if #(.W(W), .N(N), .CW(CW)) bus ();

    fir4_rr_sched #(.W(W), .N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [W-1:0] pq [N][$];
    int  m_dl [N][4];
    int  m_ptr, m_acc_cyc, m_sum, m_sch, m_last_data, m_last_ch;
    bit  m_pend;
    int  res_q[$];
    int  resch_q[$];
    int  grant_q[$];
    int  hs_count = 0;
    bit  rand_ordy = 1'b0;
    bit  tb_ordy = 1'b1;
    int  ramp_exp[5] = '{1, 3, 6, 10, 14};
    int  rr_gexp[6]  = '{0, 1, 2, 3, 0, 1};
    int  rr_dexp[8]  = '{1, 2, 3, 4, 2, 4, 6, 8};

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++)
            for (int k = 0; k < 4; k++) m_dl[c][k] = 0;
        m_ptr = 0; m_pend = 1'b0; m_acc_cyc = 0; m_sum = 0; m_sch = 0;
        m_last_data = 0; m_last_ch = 0;
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < N; c++) begin
            bus.in_valid[c]      = (pq[c].size() != 0);
            bus.in_data[c*W +: W] = (pq[c].size() != 0) ? pq[c][0] : '0;
        end
        bus.out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : tb_ordy;
    endtask

    task automatic check_res(input string tag, input int idx, input int exp_d, input int exp_c);
        if (idx < res_q.size()) begin
            check_eq({tag, "_data"}, 64'(res_q[idx]), 64'(exp_d));
            check_eq({tag, "_ch"}, 64'(resch_q[idx]), 64'(exp_c));
        end else begin
            check_eq({tag, "_missing"}, 64'(res_q.size()), 64'(idx + 1));
        end
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int  win, c, s;
        bit  exp_busy, exp_valid;
        #1;
        exp_busy  = m_pend && (cyc > m_acc_cyc);
        exp_valid = m_pend && (cyc - m_acc_cyc >= 5);
        exp_rdy   = '0;
        win       = -1;
        if (!m_pend) begin
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (bus.in_valid[c] && win < 0) win = c;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
        end
        check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check_eq("busy", 64'(bus.busy), 64'(exp_busy));
        check_eq("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check_eq("out_data", 64'(bus.out_data), 64'(m_sum));
            check_eq("out_ch", 64'(bus.out_ch), 64'(m_sch));
        end else begin
            check_eq("out_data_hold", 64'(bus.out_data), 64'(m_last_data));
            check_eq("out_ch_hold", 64'(bus.out_ch), 64'(m_last_ch));
        end
        if (exp_valid && bus.out_ready) begin
            res_q.push_back(m_sum);
            resch_q.push_back(m_sch);
            hs_count++;
            m_last_data = m_sum;
            m_last_ch   = m_sch;
            m_ptr       = (m_sch + 1) % N;
            m_pend      = 1'b0;
        end else if (win >= 0) begin
            for (int k = 3; k > 0; k--) m_dl[win][k] = m_dl[win][k-1];
            m_dl[win][0] = int'(bus.in_data[win*W +: W]);
            s = 0;
            for (int k = 0; k < 4; k++) s += m_dl[win][k];
            m_sum     = s;
            m_sch     = win;
            m_pend    = 1'b1;
            m_acc_cyc = cyc;
            grant_q.push_back(win);
        end
        for (int i = 0; i < N; i++)
            if (bus.in_valid[i] && bus.in_ready[i]) void'(pq[i].pop_front());
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic run_until_empty(input int max_cyc);
        int  n;
        bit  pending;
        n = 0;
        forever begin
            pending = m_pend;
            for (int c = 0; c < N; c++) if (pq[c].size() != 0) pending = 1'b1;
            if (!pending || n >= max_cyc) break;
            cycle();
            n++;
        end
        if (pending) check_eq("timeout", 64'(n), 64'(0));
    endtask

    task automatic apply_reset(input bit check);
        reset = 1'b1;
        #1;
        if (check) begin
            check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check_eq("rst_out_data", 64'(bus.out_data), 64'(0));
            check_eq("rst_out_ch", 64'(bus.out_ch), 64'(0));
            check_eq("rst_busy", 64'(bus.busy), 64'(0));
            check_eq("rst_in_ready", 64'(bus.in_ready), 64'(0));
        end
        model_reset();
        for (int c = 0; c < N; c++) pq[c].delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        drive_inputs();
    endtask

    initial begin
        int base, gbase, h0, n;
        reset        = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        check_eq("init_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("init_out_data", 64'(bus.out_data), 64'(0));
        check_eq("init_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        drive_inputs();

        // Ramp on channel 0.
        base = res_q.size();
        for (int v = 1; v <= 5; v++) pq[0].push_back(W'(v));
        drive_inputs();
        run_until_empty(100);
        for (int i = 0; i < 5; i++) check_res("ramp", base + i, ramp_exp[i], 0);

        // Full scale on channel 2, then one small sample on channel 1.
        base = res_q.size();
        for (int i = 0; i < 4; i++) pq[2].push_back(16'hFFFF);
        drive_inputs();
        run_until_empty(100);
        check_res("full", base + 3, 32'h3FFFC, 2);
        pq[1].push_back(16'h0001);
        drive_inputs();
        run_until_empty(50);
        check_res("iso", base + 4, 1, 1);

        // Idle hold.
        for (int i = 0; i < 20; i++) cycle();

        // Round robin from a clean state.
        apply_reset(1'b0);
        base  = res_q.size();
        gbase = grant_q.size();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) pq[c].push_back(W'(c + 1));
        drive_inputs();
        run_until_empty(200);
        for (int i = 0; i < 6; i++) begin
            if (gbase + i < grant_q.size())
                check_eq("rr_grant", 64'(grant_q[gbase + i]), 64'(rr_gexp[i]));
            else
                check_eq("rr_grant_missing", 64'(grant_q.size()), 64'(gbase + i + 1));
        end
        for (int i = 0; i < 8; i++) check_res("rr", base + i, rr_dexp[i], i % N);

        // Backpressure in HOLD.
        tb_ordy = 1'b0;
        pq[3].push_back(16'h1234);
        drive_inputs();
        n = 0;
        while (!bus.out_valid && n < 20) begin cycle(); n++; end
        check_eq("bp_reach_hold", 64'(bus.out_valid), 64'(1));
        pq[0].push_back(16'h0055);
        drive_inputs();
        h0 = hs_count;
        for (int i = 0; i < 10; i++) cycle();
        check_eq("bp_no_hs", 64'(hs_count - h0), 64'(0));
        tb_ordy = 1'b1;
        drive_inputs();
        cycle();
        check_eq("bp_one_hs", 64'(hs_count - h0), 64'(1));
        run_until_empty(50);

        // Reset in the middle of accumulation.
        pq[0].push_back(16'h0009);
        drive_inputs();
        n = 0;
        while (!m_pend && n < 20) begin cycle(); n++; end
        cycle();
        cycle();
        pq[1].push_back(16'h0005);
        drive_inputs();
        h0 = hs_count;
        apply_reset(1'b1);
        base = res_q.size();
        pq[0].push_back(16'h0007);
        drive_inputs();
        run_until_empty(50);
        check_res("post_rst", base, 7, 0);
        check_eq("rst_no_stale", 64'(hs_count - h0), 64'(1));

        // Random traffic with random backpressure.
        rand_ordy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                pq[$urandom_range(0, N - 1)].push_back(W'($urandom));
            drive_inputs();
            cycle();
        end
        rand_ordy = 1'b0;
        tb_ordy   = 1'b1;
        drive_inputs();
        run_until_empty(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir4_rr_sched.md
# fir4_rr_sched

Round-robin scheduler that shares one 4-tap moving-sum datapath (unsigned, all coefficients 1, W+2-bit result) among N input channels. Each channel keeps its own 4-sample delay line. A single shared adder accumulates the four taps of the granted channel serially, one per cycle. The block sits between N sample producers and a single downstream consumer, with valid/ready handshakes on both sides.

## Interface
- W, default 16: sample width.
- N, default 4: number of channels, legal range 2..8.
- CW, default $clog2(N): channel-index width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  N  per-channel sample valid.
- in_data  in  N*W  packed samples; channel c occupies [c*W +: W].
- in_ready  out  N  per-channel accept; at most one bit is high at a time.
- out_valid  out  1  result valid.
- out_data  out  W+2  4-tap sum of the granted channel.
- out_ch  out  CW  channel index of out_data.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high when state != IDLE.

## Operation
- Per-channel delay line d0..d3 (d0 newest). Each is W bits and resets to 0.
- Accumulator acc is W+2 bits, unsigned. It cannot overflow: 4*(2^W-1) < 2^(W+2).
- rr_ptr (CW bits) resets to 0.
- FSM states: IDLE, ACC, HOLD. Reset state is IDLE.
- **IDLE**
  - Winner g = first c with in_valid[c]=1, searching from rr_ptr upward with wrap at N.
  - in_ready[g]=1 combinationally; all other bits are 0. All bits are 0 if no in_valid.
  - On a handshake edge:
    - channel g shifts: d3<=d2, d2<=d1, d1<=d0, d0<=in_data[g].
    - ch<=g, acc<=0, k<=0, go to ACC.
- **ACC**
  - Each edge: acc<=acc+tap[k] of channel ch, then k<=k+1. tap[0..3] = d0..d3, read after the shift.
  - After the k=3 edge, go to HOLD.
  - in_ready=0 throughout; in_valid is ignored.
- **HOLD**
  - out_valid=1, out_data=acc, out_ch=ch. All three are stable until the handshake.
  - On the edge where out_valid&&out_ready: go to IDLE, rr_ptr<=(ch+1) mod N.
- Delay lines of non-granted channels never change.
- Outside HOLD: out_valid=0. out_data and out_ch retain their last values.
- Reset values: out_valid=0, out_data=0, out_ch=0, in_ready=0, busy=0.
- Reset mid-operation (any state):
  - The in-flight sum is discarded and never presented.
  - All delay lines, acc, rr_ptr and k are cleared.
  - The FSM returns to IDLE immediately, since reset is asynchronous.

## Timing
- Input accept at edge E.
- ACC edges are E+1..E+4. out_valid rises after E+4.
- Input-to-output latency is 5 cycles.
- With out_ready held high: HOLD lasts 1 cycle and the block returns to IDLE after E+5.
- Best-case throughput is one sample per 6 cycles, aggregate over all channels.
- A new input is never accepted in the same cycle as the output handshake.
- out_ready low extends HOLD indefinitely. There are no drops and no overwrite.
- Simultaneous requests are resolved in a single cycle in IDLE.
- Fairness: every requesting channel is served within N grants.
- in_ready[g] depends combinationally on in_valid. Producers must not make in_valid depend on in_ready.
- Arbitration is a priority scan of the N channels and must close in one cycle.
- No combinational path exists from in_data to out_data; out_data is registered.

## Test plan
- **Ramp on one channel.** N=4; ch0 sends 1,2,3,4,5, out_ready=1.
  - out_data must be 1,3,6,10,14, out_ch=0.
  - Each result appears 5 cycles after its accept.
- **Full scale.** ch2 sends 0xFFFF four times.
  - The 4th result must be 0x3FFFC.
  - ch0/1/3 delay lines stay 0. Checked via a later single 0x0001 on ch1, which must give 0x00001.
- **Round robin.** All four in_valid high continuously, ch c sending value c+1.
  - Grant order must be 0,1,2,3,0,1.
  - First results must be 1,2,3,4; the second round must give 2,4,6,8.
- **Backpressure.** out_ready=0 for 10 cycles in HOLD.
  - out_valid stays 1 and out_data/out_ch stay constant.
  - in_ready stays 0 and busy stays 1.
  - Releasing out_ready gives exactly one handshake, then IDLE.
- **Reset mid-ACC.** Assert reset at k=2 without a clock edge.
  - Outputs must go to reset values immediately and the FSM to IDLE.
  - After release, ch0 sending 7 must yield 7, proving the delay lines were cleared.
- **Idle hold.** No in_valid for 20 cycles: busy=0, out_valid=0, and no delay line changes.
